// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared widths, level type and helpers for the LED fade/PWM stage
package led_pkg;

    localparam int N_LEDS   = 8;
    localparam int PWM_BITS = 4;
    localparam int PWM_MAX  = (1 << PWM_BITS) - 1;
    localparam int PWM_LAST = PWM_MAX - 1;

    typedef logic [PWM_BITS-1:0] lvl_t;

    // Afterglow steps down one level and parks at zero instead of wrapping to full.
    function automatic lvl_t sat_dec(input lvl_t v);
        return (v == '0) ? '0 : v - lvl_t'(1);
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// rtl/led_fade_channel.sv - one LED channel: level register, fade update and PWM compare
module led_fade_channel
    import led_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic boundary,
    input  logic decay_due,
    input  logic led,
    input  lvl_t brightness,
    input  logic en_fade,
    input  lvl_t pwm_cnt_next,
    output logic pwm
);

    lvl_t lvl;
    lvl_t lvl_next;

    always_comb begin
        lvl_next = lvl;
        if (boundary) begin
            if (led) begin
                lvl_next = brightness;
            end else if (!en_fade) begin
                lvl_next = '0;
            end else if (decay_due) begin
                lvl_next = sat_dec(lvl);
            end
        end
    end

    // Compare against the next count so the registered output lines up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl <= '0;
            pwm <= 1'b0;
        end else begin
            lvl <= lvl_next;
            pwm <= (pwm_cnt_next < lvl_next);
        end
    end

endmodule

// File: rtl/led_fade_pwm.sv
// rtl/led_fade_pwm.sv - per-LED PWM brightness with optional afterglow decay
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int DECAY_DIV = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_LEDS-1:0] leds_in,
    input  lvl_t              brightness,
    input  logic              en_fade,
    output logic [N_LEDS-1:0] pwm_out,
    output logic              frame_start
);

    localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    if (DECAY_DIV < PWM_MAX) begin : g_div_check
        $error("led_fade_pwm: DECAY_DIV must be at least one PWM frame long");
    end

    lvl_t          pwm_cnt;
    lvl_t          pwm_cnt_next;
    logic          boundary;
    logic [DW-1:0] decay_cnt;
    logic [DW-1:0] decay_cnt_next;
    logic          decay_wrap;
    logic          decay_pend;
    logic          decay_pend_next;
    logic          decay_due;

    always_comb begin
        boundary       = (pwm_cnt == lvl_t'(PWM_LAST));
        pwm_cnt_next   = boundary ? '0 : pwm_cnt + lvl_t'(1);
        decay_wrap     = (decay_cnt == DW'(DECAY_DIV - 1));
        decay_cnt_next = decay_wrap ? '0 : decay_cnt + DW'(1);
        // A wrap landing on a boundary is consumed right there, never left pending.
        decay_due       = boundary && (decay_pend || decay_wrap);
        decay_pend_next = decay_pend;
        if (decay_due) begin
            decay_pend_next = 1'b0;
        end else if (decay_wrap) begin
            decay_pend_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt     <= '0;
            decay_cnt   <= '0;
            decay_pend  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pwm_cnt     <= pwm_cnt_next;
            decay_cnt   <= decay_cnt_next;
            decay_pend  <= decay_pend_next;
            frame_start <= (pwm_cnt_next == '0);
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_fade_channel u_ch (
            .clk          (clk),
            .rst          (rst),
            .boundary     (boundary),
            .decay_due    (decay_due),
            .led          (leds_in[i]),
            .brightness   (brightness),
            .en_fade      (en_fade),
            .pwm_cnt_next (pwm_cnt_next),
            .pwm          (pwm_out[i])
        );
    end

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Downstream stage of the LED bar controller. Takes its 8-bit LED pattern and drives the physical LED pins.
- Per-LED PWM sets brightness. An optional afterglow decays the brightness of an LED that has just turned off.
- Gives a visible comet-tail effect on the fill/drain sweep without changing the pattern generator.

Parameters:
N_LEDS, 8, number of LED channels
PWM_BITS, 4, level width; PWM period = 2^PWM_BITS-1 = 15 clocks
DECAY_DIV, 1024, clocks between decay steps; legal range >= 15 (elaboration check)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
leds_in  input  N_LEDS  LED pattern from the upstream controller, 1 = lit
brightness  input  PWM_BITS  global level for lit LEDs, 0..15
en_fade  input  1  1 = unlit LEDs decay gradually; 0 = unlit LEDs go dark at once
pwm_out  output  N_LEDS  registered LED drive
frame_start  output  1  registered, high during the cycle in which pwm_cnt==0

Behaviour:
- Reset values (async, take effect immediately, including mid-fade): pwm_cnt=0, lvl[i]=0, decay_cnt=0, decay_pend=0, pwm_out=0, frame_start=0.
- pwm_cnt counts 0..14 and wraps 14->0, so one frame is 15 clocks.
- A boundary cycle is a cycle in which pwm_cnt==14. Levels change only at the edge that ends a boundary cycle, so frames never glitch.
- leds_in and brightness are sampled only in boundary cycles. Changes that are not present in a boundary cycle are ignored.
- Level update for each channel i at the boundary edge:
  - leds_in[i]==1: lvl[i] <= brightness. This also applies when brightness changes while the LED stays lit.
  - leds_in[i]==0 and en_fade==0: lvl[i] <= 0.
  - leds_in[i]==0, en_fade==1, decay due: lvl[i] <= lvl[i]-1, saturating at 0 (never wraps to 15).
  - Otherwise lvl[i] holds.
- Decay prescaler:
  - decay_cnt counts 0..DECAY_DIV-1 freely.
  - When it wraps it sets decay_pend.
  - Decay is due at a boundary if decay_pend==1 or the wrap happens in that same boundary cycle.
  - Using decay at a boundary clears decay_pend. A simultaneous wrap does not leave the flag set.
  - One decay step is applied to all fading channels at once.
  - Pending steps never accumulate beyond 1. DECAY_DIV >= 15 guarantees this.
- PWM compare:
  - pwm_out[i] <= (pwm_cnt_next < lvl_next[i]), so the output is aligned with the counter value it represents.
  - Level 0: output always low. Level 15: output always high. Level L: high for cnt 0..L-1 of each frame.
- Latency:
  - A leds_in change present in a boundary cycle appears on pwm_out in the very next cycle (cnt=0).
  - Worst case from a leds_in change to pwm_out is 15 clocks.
- frame_start <= (pwm_cnt_next==0). The first assertion is at the 15th clock edge after reset is released.
- brightness=0: lit LEDs stay dark, and their fading starts from 0.
- Channels are independent. Multiple LEDs can be fading simultaneously at different levels.

Decomposition:
- Package led_pkg holds:
  - N_LEDS, PWM_BITS.
  - PWM_MAX = 2^PWM_BITS-1 (=15).
  - The boundary count PWM_MAX-1.
  - The level type (PWM_BITS-wide).
- Sub-module led_fade_channel holds one channel: the lvl register, update mux, saturating decrement and compare register.
  - Inputs: clk, rst, boundary, decay_due, led, brightness, en_fade, pwm_cnt_next.
  - Output: pwm bit.
  - Instantiated N_LEDS times in a generate loop.
- pwm_cnt, the decay prescaler and frame_start live in the top level.

Test Plan:
1. Reset: assert rst mid-frame with lvl nonzero -> pwm_out=8'h00 and frame_start=0 in the same cycle. After release, frame_start pulses at edge 15, then every 15 clocks.
2. brightness=15, leds_in=8'h01 held -> from the first cnt=0 cycle, pwm_out[0] is constantly 1 and pwm_out[7:1]=0.
3. brightness=5, leds_in=8'hFF -> every pwm_out bit is high exactly for cnt 0..4 (5 of 15 clocks) in each frame. Then change brightness to 0 -> all low from the next frame.
4. DECAY_DIV=30, brightness=15, en_fade=1; leds_in[3] goes 1->0 at a boundary -> lvl[3] goes 15,14,... dropping 1 every 2 frames. pwm_out[3] has 0 high clocks after 15 decay steps and stays 0 with no wrap to 15.
5. en_fade=0, brightness=9; leds_in 8'h0F->8'h00 -> pwm_out=8'h00 from the first cycle after the next boundary.
6. 3-cycle leds_in pulse that does not cover a cnt=14 cycle -> pwm_out is unchanged. Decay wrap coinciding with a boundary -> exactly one decrement is applied and decay_pend=0 afterwards.
